// File: rtl/proc_control.sv
// ---------------------------------------------------------------------------
// proc_control
//
// Multicycle instruction sequencer for the 16-bit bus processor. A 9-bit
// instruction is captured from din[8:0] in timestep T0 and executed over
// T1..T3, driving one-hot bus-source and register-load controls for the
// register file, bus mux and ALU.
//
// Instruction format: IR[8:6] opcode, IR[5:3] X, IR[2:0] Y
//   000 mv  Rx,Ry    001 mvi Rx,#D    010 add Rx,Ry    011 sub Rx,Ry
//   100..111 illegal (completes in T1 with done only)
//
// Ports
//   clk      in   system clock, rising edge
//   resetn   in   asynchronous active-low reset
//   run      in   start request, sampled only in T0
//   din      in   external data/instruction bus
//   ir_in    out  instruction-register load strobe
//   r_in     out  one-hot register load enables
//   r_out    out  one-hot register bus-drive selects
//   din_out  out  drive din onto the bus
//   g_out    out  drive G onto the bus
//   ain      out  load A
//   gin      out  load G
//   sub      out  AddSub subtract select
//   done     out  final cycle of the instruction
//   busy     out  high in T1..T3
// ---------------------------------------------------------------------------
module proc_control #(
    parameter int NREG  = 8,   // fixed by the 3-bit X/Y fields
    parameter int DIN_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run,
    input  logic [DIN_W-1:0] din,
    output logic             ir_in,
    output logic [NREG-1:0]  r_in,
    output logic [NREG-1:0]  r_out,
    output logic             din_out,
    output logic             g_out,
    output logic             ain,
    output logic             gin,
    output logic             sub,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam logic [NREG-1:0] REG0_SEL = NREG'(1);

    tstep_e     state_q, state_d;
    logic [8:0] ir_q, ir_d;

    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;

    assign opcode = ir_q[8:6];
    assign rx     = ir_q[5:3];
    assign ry     = ir_q[2:0];

    // Only din[8:0] carries the instruction; the upper bits are data only.
    logic unused_din_hi;
    assign unused_din_hi = ^din[DIN_W-1:9];

    function automatic logic [NREG-1:0] reg_sel(input logic [2:0] idx);
        return REG0_SEL << idx;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its peers; blocking here would create
    // order-dependent simulation that no longer matches the synthesized flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // NOTE: every signal written here gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ir_in   = 1'b0;
        r_in    = '0;
        r_out   = '0;
        din_out = 1'b0;
        g_out   = 1'b0;
        ain     = 1'b0;
        gin     = 1'b0;
        sub     = 1'b0;
        done    = 1'b0;
        busy    = 1'b0;

        // Gating on resetn keeps ir_in (which follows run in T0) low while
        // reset is held, so every output is forced to 0 asynchronously.
        if (resetn) begin
            busy = (state_q != T0);
            unique case (state_q)
                T0: begin
                    ir_in = run;
                    if (run) begin
                        ir_d    = din[8:0];
                        state_d = T1;
                    end
                end
                T1: begin
                    unique case (opcode)
                        OP_MV: begin
                            r_out   = reg_sel(ry);
                            r_in    = reg_sel(rx);
                            done    = 1'b1;
                            state_d = T0;
                        end
                        OP_MVI: begin
                            din_out = 1'b1;
                            r_in    = reg_sel(rx);
                            done    = 1'b1;
                            state_d = T0;
                        end
                        OP_ADD, OP_SUB: begin
                            r_out   = reg_sel(rx);
                            ain     = 1'b1;
                            state_d = T2;
                        end
                        default: begin
                            // Illegal opcode: retire without touching the datapath.
                            done    = 1'b1;
                            state_d = T0;
                        end
                    endcase
                end
                T2: begin
                    // Only add/sub reach T2.
                    r_out   = reg_sel(ry);
                    gin     = 1'b1;
                    sub     = (opcode == OP_SUB);
                    state_d = T3;
                end
                T3: begin
                    g_out   = 1'b1;
                    r_in    = reg_sel(rx);
                    done    = 1'b1;
                    state_d = T0;
                end
                default: state_d = T0;
            endcase
        end
    end

endmodule
